// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared game constants. Holds the score width, the active-low
//               seven-segment patterns and the score display FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Width of the binary score produced by the playfield renderer
    localparam int SCORE_W = 20;

    // Seven-segment patterns, bit order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Score display conversion FSM
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // BCD digit to segment pattern; anything outside 0-9 is shown blank
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/score_display_if.sv
`default_nettype none
// ============================================================================
// Module      : score_display_if
// Description : Score in, display outputs back. The renderer side uses the
//               master modport, the score display uses the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface score_display_if #(
    parameter int SCORE_W = 20,
    parameter int DIGITS  = 6
);

    logic [SCORE_W-1:0]  score;
    logic [DIGITS*7-1:0] hex;
    logic [DIGITS*4-1:0] bcd;
    logic                busy;
    logic                upd;

    modport master (
        output score,
        input  hex,
        input  bcd,
        input  busy,
        input  upd
    );

    modport slave (
        input  score,
        output hex,
        output bcd,
        output busy,
        output upd
    );

endinterface
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decoder
// Description : Combinational BCD digit to active-low seven-segment decoder
//               with a blank override. Reusable for any on-board readout.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decoder
    import game_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    // Blank wins over the digit value
    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            o_seg = seg_encode(i_bcd);
        end
    end

endmodule
`default_nettype wire

// File: rtl/score_display.sv
`default_nettype none
// ============================================================================
// Module      : score_display
// Description : Converts the renderer's binary score to BCD with a sequential
//               double-dabble engine and drives six seven-segment displays.
//               Displayed values change atomically on conversion commit.
// Revision    : 1.0 - initial release
// ============================================================================
module score_display #(
    parameter int SCORE_W       = game_pkg::SCORE_W,
    parameter int DIGITS        = 6,
    parameter int MAX_SHOW      = 999999,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic           vgaclk,
    input  logic           rst,
    score_display_if.slave bus
);

    import game_pkg::state_t;
    import game_pkg::ST_IDLE;
    import game_pkg::ST_LOAD;
    import game_pkg::ST_SHIFT;
    import game_pkg::ST_COMMIT;
    import game_pkg::SEG_0;
    import game_pkg::SEG_BLANK;

    localparam int                  c_CNT_W    = $clog2(SCORE_W);
    localparam logic [SCORE_W-1:0]  c_MAX_SHOW = SCORE_W'(MAX_SHOW);
    localparam int                  c_BCD_W    = DIGITS * 4;
    localparam int                  c_HEX_W    = DIGITS * 7;

    // Display 0 always shows "0"; the others show blank or "0"
    function automatic logic [c_HEX_W-1:0] f_hex_rst();
        logic [c_HEX_W-1:0] v;
        for (int k = 0; k < DIGITS; k++) begin
            v[7*k +: 7] = ((k == 0) || !BLANK_LEADING) ? SEG_0 : SEG_BLANK;
        end
        return v;
    endfunction

    localparam logic [c_HEX_W-1:0] c_HEX_RST = f_hex_rst();

    state_t               r_state;
    state_t               w_state_nx;
    logic [SCORE_W-1:0]   r_score_q;
    // Extra MSB flags the post-reset sentinel so any first score converts
    logic [SCORE_W:0]     r_last_conv;
    logic [SCORE_W-1:0]   r_bin_sr;
    logic [c_BCD_W-1:0]   r_bcd_sr;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_BCD_W-1:0]   r_bcd;
    logic [c_HEX_W-1:0]   r_hex;
    logic                 r_busy;
    logic                 r_upd;

    logic                 w_stable;
    logic [SCORE_W-1:0]   w_sat;
    logic [c_BCD_W-1:0]   w_bcd_adj;
    logic [DIGITS-1:0]    w_zero_from;
    logic [DIGITS-1:0]    w_blank;
    logic [c_HEX_W-1:0]   w_seg;

    // Only a score seen identically on two consecutive samples is trusted,
    // which keeps the frame-rate update edge out of the capture
    assign w_stable = (bus.score == r_score_q);
    assign w_sat    = (r_score_q > c_MAX_SHOW) ? c_MAX_SHOW : r_score_q;

    // Sample the incoming score every cycle
    always_ff @(posedge vgaclk or negedge rst) begin
        if (!rst) begin
            r_score_q <= '0;
        end else begin
            r_score_q <= bus.score;
        end
    end

    // FSM state register
    always_ff @(posedge vgaclk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FSM next-state: convert only a stable score that differs from the last one
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_stable && ({1'b0, r_score_q} != r_last_conv)) begin
                    w_state_nx = ST_LOAD;
                end
            end
            ST_LOAD:   w_state_nx = ST_SHIFT;
            ST_SHIFT: begin
                if (r_cnt == '0) begin
                    w_state_nx = ST_COMMIT;
                end
            end
            ST_COMMIT: w_state_nx = ST_IDLE;
            default:   w_state_nx = ST_IDLE;
        endcase
    end

    // Double-dabble adjust: every nibble of 5 or more gets +3 before the shift
    always_comb begin
        w_bcd_adj = r_bcd_sr;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_bcd_sr[4*k +: 4] >= 4'd5) begin
                w_bcd_adj[4*k +: 4] = r_bcd_sr[4*k +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero blanking: digit k blanks when it and every digit above are zero
    always_comb begin
        w_zero_from = '0;
        w_blank     = '0;
        w_zero_from[DIGITS-1] = (r_bcd_sr[4*(DIGITS-1) +: 4] == 4'd0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            w_zero_from[k] = w_zero_from[k+1] && (r_bcd_sr[4*k +: 4] == 4'd0);
        end
        for (int k = 1; k < DIGITS; k++) begin
            w_blank[k] = BLANK_LEADING && w_zero_from[k];
        end
    end

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            seg7_decoder u_dec (
                .i_bcd   (r_bcd_sr[4*k +: 4]),
                .i_blank (w_blank[k]),
                .o_seg   (w_seg[7*k +: 7])
            );
        end
    endgenerate

    // Conversion datapath and registered outputs; busy/upd are registered
    // from the next state so the board pins never glitch
    always_ff @(posedge vgaclk or negedge rst) begin
        if (!rst) begin
            r_last_conv <= '1;
            r_bin_sr    <= '0;
            r_bcd_sr    <= '0;
            r_cnt       <= '0;
            r_bcd       <= '0;
            r_hex       <= c_HEX_RST;
            r_busy      <= 1'b0;
            r_upd       <= 1'b0;
        end else begin
            r_busy <= (w_state_nx != ST_IDLE);
            r_upd  <= (w_state_nx == ST_COMMIT);
            case (r_state)
                ST_LOAD: begin
                    r_bin_sr    <= w_sat;
                    r_last_conv <= {1'b0, r_score_q};
                    r_bcd_sr    <= '0;
                    r_cnt       <= c_CNT_W'(SCORE_W - 1);
                end
                ST_SHIFT: begin
                    r_bcd_sr <= {w_bcd_adj[c_BCD_W-2:0], r_bin_sr[SCORE_W-1]};
                    r_bin_sr <= {r_bin_sr[SCORE_W-2:0], 1'b0};
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_COMMIT: begin
                    r_bcd <= r_bcd_sr;
                    r_hex <= w_seg;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.hex  = r_hex;
    assign bus.bcd  = r_bcd;
    assign bus.busy = r_busy;
    assign bus.upd  = r_upd;

endmodule
`default_nettype wire

// File: tb/tb_score_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_display
// Description : Directed self-checking bench for score_display.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_display;

    localparam logic [41:0] c_HEX_RST = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [41:0] c_HEX_ALL9 = {7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10};
    localparam logic [41:0] c_HEX_777 = {7'h7F, 7'h7F, 7'h7F, 7'h78, 7'h78, 7'h78};

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    score_display_if #(.SCORE_W(20), .DIGITS(6)) bus ();

    score_display #(
        .SCORE_W       (20),
        .DIGITS        (6),
        .MAX_SHOW      (999999),
        .BLANK_LEADING (1'b1)
    ) dut (
        .vgaclk (clk),
        .rst    (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts posedges from the call until upd is seen high at a negedge
    task automatic wait_upd(input int max_n, output int n, output bit got);
        got = 1'b0;
        n   = 0;
        while ((n < max_n) && !got) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (bus.upd === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        int pulses;
        rst_n     = 1'b0;
        bus.score = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.hex !== c_HEX_RST) begin n_fail++; $display("FAIL reset_hex actual=%h required=%h", bus.hex, c_HEX_RST); end
        n_checks++;
        if (bus.bcd !== 24'h0) begin n_fail++; $display("FAIL reset_bcd actual=%h required=000000", bus.bcd); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy actual=%b required=0", bus.busy); end
        n_checks++;
        if (bus.upd !== 1'b0) begin n_fail++; $display("FAIL reset_upd actual=%b required=0", bus.upd); end
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.upd === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 1) begin n_fail++; $display("FAIL reset_sentinel_upd_count actual=%0d required=1", pulses); end
        n_checks++;
        if (bus.bcd !== 24'h0) begin n_fail++; $display("FAIL reset_conv_bcd actual=%h required=000000", bus.bcd); end
        n_checks++;
        if (bus.hex !== c_HEX_RST) begin n_fail++; $display("FAIL reset_conv_hex actual=%h required=%h", bus.hex, c_HEX_RST); end
    endtask

    task automatic test_latency();
        int n;
        bit got;
        bus.score = 20'd123456;
        wait_upd(40, n, got);
        // n counts the sampling edge too, so 22 cycles after the first stable cycle is n=23
        n_checks++;
        if (!got || n != 23) begin n_fail++; $display("FAIL latency actual=%0d got=%b required=23", n, got); end
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_commit actual=%b required=1", bus.busy); end
        @(negedge clk);
        n_checks++;
        if (bus.upd !== 1'b0) begin n_fail++; $display("FAIL upd_one_cycle actual=%b required=0", bus.upd); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_commit actual=%b required=0", bus.busy); end
        n_checks++;
        if (bus.bcd !== 24'h123456) begin n_fail++; $display("FAIL bcd_123456 actual=%h required=123456", bus.bcd); end
        n_checks++;
        if (bus.hex[6:0] !== 7'h02) begin n_fail++; $display("FAIL hex0_123456 actual=%h required=02", bus.hex[6:0]); end
        n_checks++;
        if (bus.hex[41:35] !== 7'h79) begin n_fail++; $display("FAIL hex5_123456 actual=%h required=79", bus.hex[41:35]); end
    endtask

    task automatic test_saturate();
        int n;
        bit got;
        bus.score = 20'hFFFFF;
        wait_upd(40, n, got);
        @(negedge clk);
        n_checks++;
        if (!got || bus.bcd !== 24'h999999) begin n_fail++; $display("FAIL sat_max_bcd actual=%h got=%b required=999999", bus.bcd, got); end
        n_checks++;
        if (bus.hex !== c_HEX_ALL9) begin n_fail++; $display("FAIL sat_max_hex actual=%h required=%h", bus.hex, c_HEX_ALL9); end
        bus.score = 20'd999999;
        wait_upd(40, n, got);
        @(negedge clk);
        n_checks++;
        if (!got || bus.bcd !== 24'h999999) begin n_fail++; $display("FAIL sat_999999_bcd actual=%h got=%b required=999999", bus.bcd, got); end
        n_checks++;
        if (bus.hex !== c_HEX_ALL9) begin n_fail++; $display("FAIL sat_999999_hex actual=%h required=%h", bus.hex, c_HEX_ALL9); end
    endtask

    task automatic test_blank();
        int n;
        bit got;
        bus.score = 20'd42;
        wait_upd(40, n, got);
        @(negedge clk);
        n_checks++;
        if (!got || bus.bcd !== 24'h000042) begin n_fail++; $display("FAIL blank42_bcd actual=%h got=%b required=000042", bus.bcd, got); end
        n_checks++;
        if (bus.hex[41:14] !== {4{7'h7F}}) begin n_fail++; $display("FAIL blank42_upper actual=%h required=%h", bus.hex[41:14], {4{7'h7F}}); end
        n_checks++;
        if (bus.hex[13:7] !== 7'h19) begin n_fail++; $display("FAIL blank42_hex1 actual=%h required=19", bus.hex[13:7]); end
        n_checks++;
        if (bus.hex[6:0] !== 7'h24) begin n_fail++; $display("FAIL blank42_hex0 actual=%h required=24", bus.hex[6:0]); end
        bus.score = 20'd40;
        wait_upd(40, n, got);
        @(negedge clk);
        n_checks++;
        if (!got || bus.hex[6:0] !== 7'h40) begin n_fail++; $display("FAIL blank40_hex0 actual=%h got=%b required=40", bus.hex[6:0], got); end
        n_checks++;
        if (bus.hex[13:7] !== 7'h19) begin n_fail++; $display("FAIL blank40_hex1 actual=%h required=19", bus.hex[13:7]); end
    endtask

    task automatic test_midchange();
        int pulses;
        int first_i;
        int second_i;
        pulses    = 0;
        first_i   = 0;
        second_i  = 0;
        bus.score = 20'd100;
        for (int i = 1; i <= 90; i++) begin
            @(posedge clk);
            @(negedge clk);
            // i=12 is the tenth SHIFT cycle of the first conversion
            if (i == 12) bus.score = 20'd200;
            if (bus.upd === 1'b1) begin
                pulses++;
                if (pulses == 1) first_i = i;
                if (pulses == 2) second_i = i;
            end
            if (i == 24) begin
                n_checks++;
                if (bus.bcd !== 24'h000100) begin n_fail++; $display("FAIL mid_first_bcd actual=%h required=000100", bus.bcd); end
                n_checks++;
                if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle_busy actual=%b required=0", bus.busy); end
            end
            if (i == 25) begin
                n_checks++;
                if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_restart_busy actual=%b required=1", bus.busy); end
            end
            if (i == 47) begin
                n_checks++;
                if (bus.bcd !== 24'h000200) begin n_fail++; $display("FAIL mid_second_bcd actual=%h required=000200", bus.bcd); end
            end
        end
        n_checks++;
        if (first_i != 23) begin n_fail++; $display("FAIL mid_first_upd_cycle actual=%0d required=23", first_i); end
        n_checks++;
        if (second_i != 46) begin n_fail++; $display("FAIL mid_second_upd_cycle actual=%0d required=46", second_i); end
        n_checks++;
        if (pulses != 2) begin n_fail++; $display("FAIL mid_upd_count actual=%0d required=2", pulses); end
    endtask

    task automatic test_reset_mid();
        int n;
        bit got;
        bus.score = 20'd777;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before actual=%b required=1", bus.busy); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_async actual=%b required=0", bus.busy); end
        n_checks++;
        if (bus.hex !== c_HEX_RST) begin n_fail++; $display("FAIL rmid_hex_async actual=%h required=%h", bus.hex, c_HEX_RST); end
        n_checks++;
        if (bus.bcd !== 24'h0) begin n_fail++; $display("FAIL rmid_bcd_async actual=%h required=000000", bus.bcd); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_upd(60, n, got);
        @(negedge clk);
        n_checks++;
        if (!got || bus.bcd !== 24'h000777) begin n_fail++; $display("FAIL rmid_bcd_after actual=%h got=%b required=000777", bus.bcd, got); end
        n_checks++;
        if (bus.hex !== c_HEX_777) begin n_fail++; $display("FAIL rmid_hex_after actual=%h required=%h", bus.hex, c_HEX_777); end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.score = '0;
        test_reset();
        test_latency();
        repeat (4) @(negedge clk);
        test_saturate();
        repeat (4) @(negedge clk);
        test_blank();
        repeat (4) @(negedge clk);
        test_midchange();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
